// File: rtl/alu.sv
// -----------------------------------------------------------------------------
// alu -- registered integer ALU for the Fyre RV32I execute stage.
//
// The ALU computes one of ten arithmetic, logic, shift or compare operations on
// val1/val2, selected by ALU_op. The result is registered, so a value sampled
// at rising edge N appears on ALU_res just after edge N. There is no handshake,
// and the ALU accepts a new operation every cycle.
//
// Parameters
//   DATA_W   operand/result width; bit DATA_W-1 is the sign bit for signed ops
//   SHAMT_W  number of low val2 bits used as the shift amount
//            (2**SHAMT_W must not exceed DATA_W)
//
// Ports
//   clk      in   1        rising-edge clock
//   rst_n    in   1        asynchronous, active-low reset
//   ALU_op   in   4        operation select (see alu_op_e)
//   val1     in   DATA_W   operand A
//   val2     in   DATA_W   operand B / shift amount source
//   ALU_res  out  DATA_W   registered result (0 in reset)
//   zero     out  1        registered (ALU_res == 0), 1 in reset
//
// Configuration
//   ALU_ZERO_FLAG_EN  when this macro is defined, the zero port and its
//                     register exist. When it is undefined, both are absent
//                     and the rest of the ALU behaves the same.
// -----------------------------------------------------------------------------
module alu #(
   parameter int DATA_W  = 33,
   parameter int SHAMT_W = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [3:0]        ALU_op,
   input  logic [DATA_W-1:0] val1,
   input  logic [DATA_W-1:0] val2,
`ifdef ALU_ZERO_FLAG_EN
   output logic              zero,
`endif
   output logic [DATA_W-1:0] ALU_res
);

   typedef enum logic [3:0] {
      OP_ADD  = 4'b0000,
      OP_SUB  = 4'b0001,
      OP_AND  = 4'b0010,
      OP_OR   = 4'b0011,
      OP_XOR  = 4'b0100,
      OP_SLL  = 4'b0101,
      OP_SRL  = 4'b0110,
      OP_SRA  = 4'b0111,
      OP_SLT  = 4'b1000,
      OP_SLTU = 4'b1001
   } alu_op_e;

   logic [DATA_W-1:0]  res_d;
   logic [DATA_W-1:0]  res_q;
   logic [SHAMT_W-1:0] shamt;

   // The shift uses only the low SHAMT_W bits of val2. The upper bits are
   // ignored on purpose.
   assign shamt = val2[SHAMT_W-1:0];

   // Next-result selection.
   // NOTE: res_d is given a default before the case, so every path assigns it.
   // This includes the reserved and unknown opcodes, so no latch is inferred.
   always_comb begin
      res_d = '0;
      case (ALU_op)
         OP_ADD:  res_d = val1 + val2;
         OP_SUB:  res_d = val1 - val2;
         OP_AND:  res_d = val1 & val2;
         OP_OR:   res_d = val1 | val2;
         OP_XOR:  res_d = val1 ^ val2;
         OP_SLL:  res_d = val1 << shamt;
         OP_SRL:  res_d = val1 >> shamt;
         // $signed makes >>> fill with val1's sign bit instead of zeros.
         OP_SRA:  res_d = $unsigned($signed(val1) >>> shamt);
         // A signed compare stays correct when the operands sit at the
         // overflow boundary. The result is {0..,1} or 0.
         OP_SLT:  res_d = {{(DATA_W-1){1'b0}}, ($signed(val1) < $signed(val2))};
         OP_SLTU: res_d = {{(DATA_W-1){1'b0}}, (val1 < val2)};
         default: res_d = '0;   // 1010..1111 are reserved
      endcase
   end

   // Result register. Reset clears it at once, so a pending result is dropped.
   // NOTE: the clocked state uses non-blocking assignments, so every register
   // samples the values from before the edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_q <= '0;
      end else begin
         res_q <= res_d;
      end
   end

   assign ALU_res = res_q;

`ifdef ALU_ZERO_FLAG_EN
   logic zero_q;

   // The flag is derived from res_d, not res_q, so it updates on the same edge
   // as the result it describes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         zero_q <= 1'b1;
      end else begin
         zero_q <= (res_d == '0);
      end
   end

   assign zero = zero_q;
`endif

endmodule

// File: tb/tb_alu.sv
// -----------------------------------------------------------------------------
// tb_alu -- table-driven self-checking bench for alu.
// -----------------------------------------------------------------------------
module tb_alu;

   localparam int DATA_W  = 33;
   localparam int SHAMT_W = 5;

   typedef logic [DATA_W-1:0] word_t;

   typedef struct {
      string      name;
      logic [3:0] op;
      word_t      a;
      word_t      b;
      word_t      exp;
   } vec_t;

   localparam word_t ONES = {DATA_W{1'b1}};
   localparam word_t MSB  = word_t'(1) << (DATA_W-1);

   logic       clk;
   logic       rst_n;
   logic [3:0] ALU_op;
   word_t      val1;
   word_t      val2;
   word_t      ALU_res;
`ifdef ALU_ZERO_FLAG_EN
   logic       zero;
`endif

   int total;
   int bad;

   alu #(.DATA_W(DATA_W), .SHAMT_W(SHAMT_W)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ALU_op  (ALU_op),
      .val1    (val1),
      .val2    (val2),
`ifdef ALU_ZERO_FLAG_EN
      .zero    (zero),
`endif
      .ALU_res (ALU_res)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input word_t act, input word_t exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_zero(input string name, input word_t exp_res);
`ifdef ALU_ZERO_FLAG_EN
      total++;
      if (zero !== (exp_res == '0)) begin
         bad++;
         $display("FAIL %s zero: got %0b expected %0b", name, zero, (exp_res == '0));
      end
`endif
   endtask

   vec_t vecs[$];

   initial begin
      total = 0;
      bad   = 0;

      // Directed vectors with hand-computed results.
      vecs.push_back('{"add",        4'd0,  word_t'('hFF), word_t'('h55), word_t'('h154)});
      vecs.push_back('{"sub",        4'd1,  word_t'('hFF), word_t'('h55), word_t'('hAA)});
      vecs.push_back('{"and",        4'd2,  word_t'('hFF), word_t'('h55), word_t'('h55)});
      vecs.push_back('{"or",         4'd3,  word_t'('hFF), word_t'('h55), word_t'('hFF)});
      vecs.push_back('{"xor",        4'd4,  word_t'('hFF), word_t'('h55), word_t'('hAA)});
      vecs.push_back('{"sll21",      4'd5,  word_t'('hFF), word_t'('h55), word_t'('h1FE00000)});
      vecs.push_back('{"srl21",      4'd6,  word_t'('hFF), word_t'('h55), word_t'('h0)});
      vecs.push_back('{"sra21",      4'd7,  word_t'('hFF), word_t'('h55), word_t'('h0)});
      vecs.push_back('{"slt_ff_55",  4'd8,  word_t'('hFF), word_t'('h55), word_t'('h0)});
      vecs.push_back('{"sltu_ff_55", 4'd9,  word_t'('hFF), word_t'('h55), word_t'('h0)});
      vecs.push_back('{"add_wrap",   4'd0,  ONES,          word_t'('h1),  word_t'('h0)});
      vecs.push_back('{"sub_wrap",   4'd1,  word_t'('h0),  word_t'('h1),  ONES});
      vecs.push_back('{"sra_msb4",   4'd7,  MSB,           word_t'('h4),  word_t'('h1F0000000)});
      vecs.push_back('{"sra_hi_ign", 4'd7,  word_t'('h180000000), word_t'('h100000023), word_t'('h1F0000000)});
      vecs.push_back('{"sll_sh0",    4'd5,  word_t'('h123456789), word_t'('h40), word_t'('h123456789)});
      vecs.push_back('{"sll_sh31",   4'd5,  word_t'('h1),  word_t'('h1F), word_t'('h80000000)});
      vecs.push_back('{"srl_sh31",   4'd6,  MSB,           word_t'('h1F), word_t'('h2)});
      vecs.push_back('{"slt_minneg", 4'd8,  MSB,           word_t'('h0),  word_t'('h1)});
      vecs.push_back('{"slt_pos_neg",4'd8,  word_t'('h0FFFFFFFF), MSB,    word_t'('h0)});
      vecs.push_back('{"slt_eq",     4'd8,  word_t'('h77), word_t'('h77), word_t'('h0)});
      vecs.push_back('{"sltu_eq",    4'd9,  MSB,           MSB,           word_t'('h0)});
      vecs.push_back('{"sltu_lt",    4'd9,  word_t'('h5),  MSB,           word_t'('h1)});
      vecs.push_back('{"sltu_big",   4'd9,  ONES,          word_t'('h1),  word_t'('h0)});
      vecs.push_back('{"slt_neg1",   4'd8,  ONES,          word_t'('h1),  word_t'('h1)});
      for (int r = 10; r < 16; r++)
         vecs.push_back('{$sformatf("rsvd%0d", r), 4'(r), word_t'('hFF), word_t'('h55), word_t'('h0)});

      // Reset while the clock keeps running.
      rst_n  = 1'b0;
      ALU_op = 4'd0;
      val1   = word_t'('hFF);
      val2   = word_t'('h55);
      repeat (3) @(posedge clk);
      #1;
      check("reset_hold", ALU_res, '0);
      check_zero("reset_hold", '0);

      // The first capture happens on the first edge after release.
      rst_n = 1'b1;
      #1;
      check("after_release_pre_edge", ALU_res, '0);
      @(posedge clk);
      #1;
      check("first_capture", ALU_res, word_t'('h154));
      check_zero("first_capture", word_t'('h154));

      // An asynchronous reset between edges drops the result without a clock edge.
      #2;
      rst_n = 1'b0;
      #1;
      check("async_clear", ALU_res, '0);
      check_zero("async_clear", '0);
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      #1;
      check("released_before_edge", ALU_res, '0);
      @(posedge clk);
      #1;
      check("recapture", ALU_res, word_t'('h154));

      // Back-to-back table vectors, with a new op every cycle. Just before each
      // edge the output must still hold the previous result. Just after the
      // edge it must show the new one.
      begin
         word_t prev;
         prev = word_t'('h154);
         foreach (vecs[i]) begin
            ALU_op = vecs[i].op;
            val1   = vecs[i].a;
            val2   = vecs[i].b;
            #1;
            check({vecs[i].name, "_hold"}, ALU_res, prev);
            @(posedge clk);
            #1;
            check(vecs[i].name, ALU_res, vecs[i].exp);
            check_zero(vecs[i].name, vecs[i].exp);
            prev = vecs[i].exp;
         end
      end

      // Reset asserted while results are streaming.
      ALU_op = 4'd3;
      val1   = word_t'('hF0);
      val2   = word_t'('h0F);
      @(posedge clk);
      #1;
      check("stream_or", ALU_res, word_t'('hFF));
      #3;
      rst_n = 1'b0;
      #1;
      check("stream_reset", ALU_res, '0);
      #5;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("stream_resume", ALU_res, word_t'('hFF));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
